// File: rtl/hazard3_shift_pipe.sv
// hazard3_shift_pipe
//   Registered issue/retire wrapper around the combinational barrel shifter.
//   Requests arrive over valid/ready and pass through three registers:
//     S  (s_valid) skid register, only used when R1 cannot take a request
//     R1 (v1)      operand stage; drives the external shifter through sh_*
//     R2 (v2)      result stage; this is the response register
//   The pipeline runs at full throughput. A request is captured into R1 on
//   the edge that accepts it, and the result is valid after the following
//   edge. Responses keep strict FIFO order.
//
// Optional feature macro: HAZARD3_SHIFT_ROTATE_EN
//   defined     : ROL/ROR are legal, and the decode drives sh_rotate.
//   not defined : sh_rotate is tied to 0, and ops 3/4 are treated as illegal.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake; req_ready is a register (== !s_valid)
//   req_op            0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal
//   req_din           operand
//   req_shamt         shift amount; only the low W_SHAMT bits are used
//   req_tag           opaque tag, returned with the response
//   sh_*              to/from the combinational barrel shifter
//   resp_valid/ready  response handshake
//   resp_data         result (0 when the op was illegal)
//   resp_tag          tag of this response
//   resp_err          the op was illegal
module hazard3_shift_pipe #(
  parameter int W_DATA  = 32,
  parameter int W_SHAMT = 5,
  parameter int W_TAG   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [W_DATA-1:0]  req_din,
  input  logic [7:0]         req_shamt,
  input  logic [W_TAG-1:0]   req_tag,
  output logic [W_DATA-1:0]  sh_din,
  output logic [W_SHAMT-1:0] sh_shamt,
  output logic               sh_right_nleft,
  output logic               sh_rotate,
  output logic               sh_arith,
  input  logic [W_DATA-1:0]  sh_dout,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [W_DATA-1:0]  resp_data,
  output logic [W_TAG-1:0]   resp_tag,
  output logic               resp_err
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic [2:0]         op;
    logic [W_DATA-1:0]  din;
    logic [W_SHAMT-1:0] shamt;
    logic [W_TAG-1:0]   tag;
  } req_t;

  req_t s_q, r1_q, in_req;
  logic s_valid, v1, v2;
  logic accept, adv1, adv2, s_load, s_drain, s_valid_nxt;
  logic r1_err;

  // The upper shift-amount bits are ignored, so shamt >= W_DATA wraps.
  logic unused_shamt;
  assign unused_shamt = ^req_shamt[7:W_SHAMT];

  assign in_req = '{op: req_op, din: req_din, shamt: req_shamt[W_SHAMT-1:0], tag: req_tag};

  assign accept = req_valid && req_ready;
  assign adv2   = !v2 || resp_ready;
  assign adv1   = !v1 || adv2;

  // S takes a new request only when R1 is busy, or when R1 is taking the
  // older request already held in S. This keeps FIFO order.
  assign s_drain     = adv1 && s_valid;
  assign s_load      = accept && (!adv1 || s_valid);
  assign s_valid_nxt = s_load || (s_valid && !s_drain);

  assign resp_valid = v2;

  // Decode from R1. When R1 is empty, the sh_* outputs hold their last
  // values because r1_q is not reloaded.
  always_comb begin
    sh_din         = r1_q.din;
    sh_shamt       = r1_q.shamt;
    sh_right_nleft = 1'b0;
    sh_rotate      = 1'b0;
    sh_arith       = 1'b0;
    r1_err         = 1'b0;
    case (r1_q.op)
      OP_SLL: ;
      OP_SRL: sh_right_nleft = 1'b1;
      OP_SRA: begin
        sh_right_nleft = 1'b1;
        sh_arith       = 1'b1;
      end
`ifdef HAZARD3_SHIFT_ROTATE_EN
      OP_ROL: sh_rotate = 1'b1;
      OP_ROR: begin
        sh_right_nleft = 1'b1;
        sh_rotate      = 1'b1;
      end
`else
      OP_ROL, OP_ROR: r1_err = 1'b1;
`endif
      default: r1_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_valid   <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      req_ready <= 1'b1;
      s_q       <= '0;
      r1_q      <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
      resp_err  <= 1'b0;
    end else begin
      // R2: the result is captured only from a valid R1, so the outputs stay
      // quiet while the pipe is empty and stay stable while stalled.
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          resp_data <= r1_err ? '0 : sh_dout;
          resp_tag  <= r1_q.tag;
          resp_err  <= r1_err;
        end
      end
      // R1
      if (adv1) begin
        if (s_valid) begin
          r1_q <= s_q;
          v1   <= 1'b1;
        end else if (accept) begin
          r1_q <= in_req;
          v1   <= 1'b1;
        end else begin
          v1 <= 1'b0;
        end
      end
      // S
      if (s_load) s_q <= in_req;
      s_valid   <= s_valid_nxt;
      req_ready <= !s_valid_nxt;
    end
  end

endmodule

// File: tb/tb_hazard3_shift_pipe.sv
module tb_hazard3_shift_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_din;
  logic [7:0]   req_shamt;
  logic [3:0]   req_tag;
  logic [W-1:0] sh_din;
  logic [4:0]   sh_shamt;
  logic         sh_right_nleft, sh_rotate, sh_arith;
  logic [W-1:0] sh_dout;
  logic         resp_valid, resp_ready;
  logic [W-1:0] resp_data;
  logic [3:0]   resp_tag;
  logic         resp_err;

  hazard3_shift_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_din(req_din), .req_shamt(req_shamt), .req_tag(req_tag),
    .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_right_nleft(sh_right_nleft),
    .sh_rotate(sh_rotate), .sh_arith(sh_arith), .sh_dout(sh_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational barrel shifter.
  logic [2*W-1:0] dd;
  always_comb begin
    dd = {sh_din, sh_din};
    if (sh_rotate) begin
      if (sh_right_nleft) sh_dout = W'(dd >> sh_shamt);
      else                sh_dout = W'((dd << sh_shamt) >> W);
    end else if (sh_right_nleft) begin
      if (sh_arith) sh_dout = W'($signed(sh_din) >>> sh_shamt);
      else          sh_dout = sh_din >> sh_shamt;
    end else begin
      sh_dout = sh_din << sh_shamt;
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   tag;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  bit           prev_stall = 0;
  logic [W-1:0] held_data;
  logic [3:0]   held_tag;
  logic         held_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference result, computed one bit position at a time from the op rules.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] din,
                                     input logic [7:0] shamt, input logic [3:0] tag);
    exp_t e;
    int   s;
    logic [W-1:0] x;
    bit   legal;
    s = shamt % W;
    x = din;
    legal = 1;
    case (op)
      3'd0: for (int i = 0; i < s; i++) x = {x[W-2:0], 1'b0};
      3'd1: for (int i = 0; i < s; i++) x = {1'b0, x[W-1:1]};
      3'd2: for (int i = 0; i < s; i++) x = {x[W-1], x[W-1:1]};
`ifdef HAZARD3_SHIFT_ROTATE_EN
      3'd3: for (int i = 0; i < s; i++) x = {x[W-2:0], x[W-1]};
      3'd4: for (int i = 0; i < s; i++) x = {x[0], x[W-1:1]};
`endif
      default: legal = 0;
    endcase
    e.data = legal ? x : '0;
    e.tag  = tag;
    e.err  = !legal;
    return e;
  endfunction

  // One clock cycle. Inputs are already set. The handshakes are sampled
  // here, 1 time unit after the previous rising edge.
  task automatic tick();
    exp_t e;
    if (prev_stall) begin
      chk("stall_data", resp_data, held_data);
      chk("stall_tag",  resp_tag,  held_tag);
      chk("stall_err",  resp_err,  held_err);
    end
    if (rst_n) begin
      if (req_valid && req_ready) q.push_back(ref_model(req_op, req_din, req_shamt, req_tag));
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) chk("spurious_resp", 1, 0);
        else begin
          e = q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_tag",  resp_tag,  e.tag);
          chk("resp_err",  resp_err,  e.err);
        end
      end
      prev_stall = resp_valid && !resp_ready;
      held_data = resp_data; held_tag = resp_tag; held_err = resp_err;
    end else prev_stall = 0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] din,
                      input logic [7:0] shamt, input logic [3:0] tag);
    bit done = 0;
    req_valid = 1; req_op = op; req_din = din; req_shamt = shamt; req_tag = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      done = req_ready;
      tick();
    end
    if (!done) chk("req_timeout", 0, 1);
    req_valid = 0;
  endtask

  task automatic drain();
    resp_ready = 1; req_valid = 0;
    for (int i = 0; i < 100 && (q.size() != 0 || resp_valid); i++) tick();
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    int drop_at, sent;
    bit acc;
    rst_n = 0; req_valid = 0; req_op = 0; req_din = 0; req_shamt = 0; req_tag = 0;
    resp_ready = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1;
    chk("rst_req_ready",  req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data",  resp_data, 0);
    chk("rst_resp_tag",   resp_tag, 0);
    chk("rst_resp_err",   resp_err, 0);
    chk("rst_sh", {sh_din, sh_shamt, sh_right_nleft, sh_rotate, sh_arith}, 0);

    // Latency: the result is valid after the edge that follows the accept edge.
    send(3'd0, 32'h1, 8'd31, 4'd3);
    chk("lat_not_early", resp_valid, 0);
    tick();
    chk("lat_valid", resp_valid, 1);
    chk("lat_data",  resp_data, 32'h8000_0000);
    drain();

    send(3'd2, 32'h8000_0000, 8'd4, 4'd1);
    send(3'd1, 32'h8000_0000, 8'd4, 4'd2);
    send(3'd1, 32'h8000_0000, 8'd36, 4'd4);
    send(3'd4, 32'h0000_00F1, 8'd4, 4'd5);
    send(3'd3, 32'hF000_000F, 8'd4, 4'd6);
    send(3'd0, 32'h0000_000F, 8'd1, 4'd7);
    send(3'd6, 32'h1234_5678, 8'd2, 4'd9);
    send(3'd0, 32'h0000_000F, 8'd2, 4'd8);
    drain();

    // Back-to-back stream while the sink stalls for 5 cycles.
    sent = 0; drop_at = -1;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      req_valid = 1; req_op = 3'd0; req_din = 32'h1 << c; req_shamt = 8'(c);
      req_tag = 4'(sent);
      resp_ready = (c >= 5);
      if (!req_ready && drop_at < 0) drop_at = sent;
      acc = req_ready;
      tick();
      if (acc) sent++;
    end
    chk("stream_sent", sent, 8);
    chk("ready_drop_after", drop_at, 3);
    drain();

    // Reset with three requests in flight.
    resp_ready = 0;
    send(3'd0, 32'h1, 8'd1, 4'd1);
    send(3'd0, 32'h2, 8'd1, 4'd2);
    send(3'd0, 32'h3, 8'd1, 4'd3);
    rst_n = 0;
    tick();
    q.delete();
    rst_n = 1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready",  req_ready, 1);
    resp_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_quiet", resp_valid, 0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_op     = 3'($urandom_range(0, 7));
      req_din    = $urandom;
      req_shamt  = 8'($urandom);
      req_tag    = 4'($urandom);
      resp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
